turing_unary_alu: RTL and testbench
===================================

Name: turing_unary_alu

Overview:
- Parametrised single-tape unary Turing-machine arithmetic unit: the next generation of the fixed 3-bit unary adder.
- Adds a start/busy/done handshake, an operand width parameter, an ADD or SUB (monus) mode, and a sequential tape scan that produces a binary result.
- Used as a teaching/demo datapath block driven by a bench or small controller; the tape is visible on `seq` for waveform inspection.

Parameters:
W, 3, operand width in bits; operand values 0..2**W-1
TAPE_LEN, localparam = 2*(2**W)+3 (19 at W=3), tape length in cells

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin operation; sampled only when idle
mode  input  1  0 = ADD (a+b), 1 = SUB (max(a-b,0)); sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; c and borrow are valid from this cycle
c  output  W+1  binary result; held until the next accepted start
borrow  output  1  SUB only: 1 when b>a (result saturated to 0)
seq  output  TAPE_LEN  live tape; bit i = cell i

Behaviour:
- Reset, asynchronous, active-low, wins over everything mid-operation: state IDLE, seq=0, head=0, c=0, borrow=0, busy=0, done=0.
- Encoding: value v is written as v+1 contiguous ones.
- Load, at the edge where IDLE sees start=1:
  - cell 0 = 0
  - cells 1..a+1 = 1
  - cell a+2 = 0
  - cells a+3..a+b+3 = 1
  - all other cells = 0
  - head=1, borrow=0, busy=1
- start while busy is ignored. One tape action per clock in every state.
- ADD states:
  - AD_ERASE: write 0, head+1 -> AD_SCANA.
  - AD_SCANA: cell 1 -> head+1. Cell 0 -> write 1, head+1 -> AD_SCANB.
  - AD_SCANB: cell 1 -> head+1. Cell 0 -> head-1 -> AD_TRIM.
  - AD_TRIM: write 0 -> COUNT.
  - ADD operation takes exactly a+b+5 cycles.
- SUB states:
  - SB_SEEK: cell 1 -> head+1. Cell 0 -> head+1 -> SB_PRE.
  - SB_PRE: write 0 (removes b bias one). If cell head+1 is 0 (b=0) -> COUNT. Else -> SB_FWD.
  - SB_FWD: head+1 until head==TAPE_LEN-1 -> SB_FIND.
  - SB_FIND: cell 0 -> head-1. Cell 1 -> SB_EB. The rightmost 1 on the tape is always the last b one.
  - SB_EB: write 0; last <= (cell head-1 == 0); head-1 -> SB_BACK.
  - SB_BACK: head-1 until head==0 -> SB_FA.
  - SB_FA: cell 0 -> head+1. Cell 1, i.e. leftmost a one:
    - if cell head+1==1: write 0;
    - else: borrow<=1, tape unchanged (a already 0);
    - then COUNT if last, else SB_FWD.
- COUNT:
  - scans cells 0..TAPE_LEN-1, one per cycle, accumulating ones.
  - At the last cell: c <= ones-1 (W+1 bits, no overflow; max 2*(2**W-1)), done<=1 for one cycle, busy<=0 -> IDLE.
- ADD latency: done is high in the cycle after edge a+b+5+TAPE_LEN counted from the start-sampling edge. At W=3, a=b=5 this is 34.
- seq keeps the final tape after done until the next start or reset.

Optional Feature:
- Macro TURING_STEPCNT_EN.
- Defined:
  - adds output steps [15:0], cleared on reset and on accepted start;
  - increments every cycle in a non-IDLE, non-COUNT state; saturates at 16'hFFFF;
  - held after done.
- Undefined: no steps port, no counter logic; all other behaviour identical.

Test Plan:
- Reset, then ADD a=5 b=5 -> done 34 edges after start; c=10, borrow=0; seq ones exactly at cells 2..12; busy high throughout the operation.
- ADD a=7 b=7 -> c=14; seq ones at cells 2..16. ADD a=0 b=0 -> c=0; single one at cell 2.
- SUB a=6 b=2 -> c=4, borrow=0. SUB a=3 b=0 -> c=3, borrow=0, via the SB_PRE early exit.
- SUB a=2 b=5 -> c=0, borrow=1; exactly one 1 remains on the tape.
- start pulsed again mid-operation with different a/b -> ignored; result matches the first operands. Then assert rst mid-SB_FWD -> all outputs and seq 0 immediately; next start runs normally.
- With TURING_STEPCNT_EN: ADD a=5 b=5 -> steps=15 at done.

Source files
------------

// File: rtl/turing_unary_alu.sv
// Single-tape unary Turing-machine ALU: ADD (a+b) or SUB (monus) on a
// unary-encoded tape, followed by a scan that counts the result into binary.
// Optional macro TURING_STEPCNT_EN adds a saturating 16-bit step counter
// output (steps) covering the compute states.
module turing_unary_alu #(
    parameter int unsigned W = 3,
    localparam int unsigned TAPE_LEN = 2 * (2 ** W) + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic                busy,
    output logic                done,
    output logic [W:0]          c,
    output logic                borrow,
    output logic [TAPE_LEN-1:0] seq
`ifdef TURING_STEPCNT_EN
    ,
    output logic [15:0]         steps
`endif
);

    localparam int unsigned HW = $clog2(TAPE_LEN);
    localparam int unsigned OW = $clog2(TAPE_LEN + 1);
    localparam logic [HW-1:0] LAST_CELL = HW'(TAPE_LEN - 1);

    typedef enum logic [3:0] {
        IDLE,
        AD_ERASE,
        AD_SCANA,
        AD_SCANB,
        AD_TRIM,
        SB_SEEK,
        SB_PRE,
        SB_FWD,
        SB_FIND,
        SB_EB,
        SB_BACK,
        SB_FA,
        COUNT
    } state_t;

    state_t              state_q, state_d;
    logic [TAPE_LEN-1:0] seq_q, seq_d;
    logic [HW-1:0]       head_q, head_d;
    logic [OW-1:0]       ones_q, ones_d;
    logic [W:0]          c_q, c_d;
    logic                borrow_q, borrow_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                last_q, last_d;
`ifdef TURING_STEPCNT_EN
    logic [15:0]         steps_q, steps_d;
`endif

    logic [HW-1:0]       hp1, hm1;
    logic                cur, nxt, prv;
    logic [OW-1:0]       total;
    logic [TAPE_LEN-1:0] load_tape;

    // Neighbouring cell reads around the head, guarded at the tape ends
    always_comb begin
        hp1   = head_q + HW'(1);
        hm1   = head_q - HW'(1);
        cur   = seq_q[head_q];
        nxt   = (head_q < LAST_CELL) ? seq_q[hp1] : 1'b0;
        prv   = (head_q != '0) ? seq_q[hm1] : 1'b0;
        total = ones_q + OW'(cur);
    end

    // Initial tape image: 0, a+1 ones, 0, b+1 ones, zeros
    always_comb begin
        load_tape = (((TAPE_LEN'(1) << (32'(a) + 32'd1)) - TAPE_LEN'(1)) << 1)
                  | (((TAPE_LEN'(1) << (32'(b) + 32'd1)) - TAPE_LEN'(1)) << (32'(a) + 32'd3));
    end

    // Next-state, tape action and output computation
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        head_d   = head_q;
        ones_d   = ones_q;
        c_d      = c_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    seq_d    = load_tape;
                    head_d   = HW'(1);
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                    last_d   = 1'b0;
                    state_d  = mode ? SB_SEEK : AD_ERASE;
                end
            end
            AD_ERASE: begin
                seq_d[head_q] = 1'b0;
                head_d        = hp1;
                state_d       = AD_SCANA;
            end
            AD_SCANA: begin
                head_d = hp1;
                if (!cur) begin
                    seq_d[head_q] = 1'b1;
                    state_d       = AD_SCANB;
                end
            end
            AD_SCANB: begin
                if (cur) begin
                    head_d = hp1;
                end else begin
                    head_d  = hm1;
                    state_d = AD_TRIM;
                end
            end
            AD_TRIM: begin
                seq_d[head_q] = 1'b0;
                head_d        = '0;
                ones_d        = '0;
                state_d       = COUNT;
            end
            SB_SEEK: begin
                head_d = hp1;
                if (!cur) begin
                    state_d = SB_PRE;
                end
            end
            SB_PRE: begin
                seq_d[head_q] = 1'b0;
                if (!nxt) begin
                    head_d  = '0;
                    ones_d  = '0;
                    state_d = COUNT;
                end else begin
                    state_d = SB_FWD;
                end
            end
            SB_FWD: begin
                if (head_q == LAST_CELL) begin
                    state_d = SB_FIND;
                end else begin
                    head_d = hp1;
                end
            end
            SB_FIND: begin
                if (cur) begin
                    state_d = SB_EB;
                end else begin
                    head_d = hm1;
                end
            end
            SB_EB: begin
                seq_d[head_q] = 1'b0;
                last_d        = !prv;
                head_d        = hm1;
                state_d       = SB_BACK;
            end
            SB_BACK: begin
                if (head_q == '0) begin
                    state_d = SB_FA;
                end else begin
                    head_d = hm1;
                end
            end
            SB_FA: begin
                if (!cur) begin
                    head_d = hp1;
                end else begin
                    if (nxt) begin
                        seq_d[head_q] = 1'b0;
                    end else begin
                        borrow_d = 1'b1;
                    end
                    if (last_q) begin
                        head_d  = '0;
                        ones_d  = '0;
                        state_d = COUNT;
                    end else begin
                        state_d = SB_FWD;
                    end
                end
            end
            COUNT: begin
                ones_d = total;
                if (head_q == LAST_CELL) begin
                    c_d     = (W+1)'(total - OW'(1));
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    head_d = hp1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TURING_STEPCNT_EN
    // Saturating count of compute-state cycles, cleared on accepted start
    always_comb begin
        steps_d = steps_q;
        if (state_q == IDLE) begin
            if (start) begin
                steps_d = '0;
            end
        end else if (state_q != COUNT && steps_q != 16'hFFFF) begin
            steps_d = steps_q + 16'd1;
        end
    end

    // Step counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            steps_q <= '0;
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`endif

    // State, tape and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            seq_q    <= '0;
            head_q   <= '0;
            ones_q   <= '0;
            c_q      <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            head_q   <= head_d;
            ones_q   <= ones_d;
            c_q      <= c_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            last_q   <= last_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign c      = c_q;
    assign borrow = borrow_q;
    assign seq    = seq_q;

endmodule

// File: tb/tb_turing_unary_alu.sv
// Directed plus randomized bench for turing_unary_alu, checked against an
// arithmetic model of the final tape, result, borrow and ADD latency.
module tb_turing_unary_alu;

    localparam int unsigned W  = 3;
    localparam int unsigned TL = 2 * (2 ** W) + 3;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          start  = 1'b0;
    logic          mode   = 1'b0;
    logic [W-1:0]  a      = '0;
    logic [W-1:0]  b      = '0;
    logic          busy;
    logic          done;
    logic [W:0]    c;
    logic          borrow;
    logic [TL-1:0] seq;
`ifdef TURING_STEPCNT_EN
    logic [15:0]   steps;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    turing_unary_alu #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .c      (c),
        .borrow (borrow),
        .seq    (seq)
`ifdef TURING_STEPCNT_EN
        ,
        .steps  (steps)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Expected final tape: ADD leaves a+b+1 ones from cell 2; SUB erases
    // min(a,b) ones from the left of a's block at cells 1..a+1.
    function automatic logic [TL-1:0] exp_tape(input bit m, input int unsigned x, input int unsigned y);
        logic [TL-1:0] t;
        int unsigned   k;
        t = '0;
        if (!m) begin
            for (int unsigned i = 2; i <= x + y + 2; i++) t = t | (TL'(1) << i);
        end else begin
            k = (x < y) ? x : y;
            for (int unsigned i = 1 + k; i <= x + 1; i++) t = t | (TL'(1) << i);
        end
        return t;
    endfunction

    task automatic do_op(input bit m, input int unsigned x, input int unsigned y, input bit inject);
        int unsigned n;
        bit          busy_ok;
        int unsigned exp_c;
        bit          exp_b;
        exp_c = m ? ((x >= y) ? x - y : 0) : x + y;
        exp_b = m && (y > x);
        @(negedge clk);
        start = 1'b1; mode = m; a = W'(x); b = W'(y);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (done !== 1'b1) busy_ok = busy_ok && (busy === 1'b1);
            if (inject && n == 3) begin
                start = 1'b1; mode = ~m; a = ~a; b = ~b;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        if (!m) chk("add_latency", n, x + y + 5 + TL);
        chk("busy_during_op", 32'(busy_ok), 32'd1);
        chk("busy_low_at_done", 32'(busy), 32'd0);
        chk("result_c", 32'(c), exp_c);
        chk("borrow", 32'(borrow), 32'(exp_b));
        chk("tape", 32'(seq), 32'(exp_tape(m, x, y)));
`ifdef TURING_STEPCNT_EN
        if (!m) chk("steps", 32'(steps), x + y + 5);
`endif
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("c_held", 32'(c), exp_c);
        chk("tape_held", 32'(seq), 32'(exp_tape(m, x, y)));
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_c", 32'(c), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        chk("rst_seq", 32'(seq), 32'd0);
        rst = 1'b1;

        do_op(1'b0, 5, 5, 1'b0);
        do_op(1'b0, 7, 7, 1'b0);
        do_op(1'b0, 0, 0, 1'b0);
        do_op(1'b1, 6, 2, 1'b0);
        do_op(1'b1, 3, 0, 1'b0);
        do_op(1'b1, 2, 5, 1'b0);
        do_op(1'b0, 4, 1, 1'b1);
        do_op(1'b1, 5, 3, 1'b1);

        // Reset asserted while SUB is scanning forward
        @(negedge clk);
        start = 1'b1; mode = 1'b1; a = W'(2); b = W'(5);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_c", 32'(c), 32'd0);
        chk("midrst_borrow", 32'(borrow), 32'd0);
        chk("midrst_seq", 32'(seq), 32'd0);
`ifdef TURING_STEPCNT_EN
        chk("midrst_steps", 32'(steps), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        do_op(1'b1, 7, 4, 1'b0);

        for (int i = 0; i < 16; i++) begin
            do_op(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
